// File: rtl/chunked_adder_if.sv
// Operand/result bus for chunked_adder. The requester drives the operands
// and start; the adder returns the result, flags and status.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, A, B, cin,
    input  S, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, A, B, cin,
    output S, cout, ovf, busy, done
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, least
// significant chunk first, rippling the carry through a register.
// Subtraction is A + ~B + 1. Result and flags are registered and held
// until the next accepted start.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             reset,
  chunked_adder_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_c_into_msb;

  assign w_accept  = bus.start && (r_state != RUN);
  assign w_last    = (r_k == KW'(N - 1));
  assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit recovered from its sum bit and operand bits.
  assign w_c_into_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: start is honoured in IDLE and DONE, ignored in RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch; B is stored already inverted for subtraction.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.A;
      r_b <= bus.sub ? ~bus.B : bus.B;
    end
  end

  // Chunk sequencing, carry ripple, result and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_k     <= '0;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
    end else if (r_state == RUN) begin
      r_s[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry <= w_sum[CHUNK];
      if (w_last) begin
        r_k    <= '0;
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_sum[CHUNK] ^ w_c_into_msb;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign bus.S    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
endmodule
